// File: rtl/uart_b_rx_if.sv
// Byte handshake between the receiver and its consumer.
// rx_valid is a level; rx_ack clears it (and overrun).
interface uart_b_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ack;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ack
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ack
  );
endinterface

// File: rtl/uart_b_rx.sv
// 8N1 serial receiver with 16x oversampling, framing-error pulse and sticky overrun.
// The received byte is handed out through a valid/ack interface.
module uart_b_rx #(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_en_i,
  input  logic [DIV_W-1:0] baud_div_i,
  input  logic             rx_in_i,
  output logic             frame_err_o,
  output logic             overrun_o,
  output logic             busy_o,
  uart_b_rx_if.master      rx_if
);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, rxs_q;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [3:0]           os_q, os_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ovr_q, ovr_d;
  logic                 ferr_q, ferr_d;
  logic                 tick;

  assign tick = (div_q == baud_div_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
      state_q <= S_IDLE;
      div_q   <= '0;
      os_q    <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx_in_i;
      rxs_q   <= sync1_q;
      state_q <= state_d;
      div_q   <= div_d;
      os_q    <= os_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    os_d    = os_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    ferr_d  = 1'b0;

    if (rx_if.rx_ack) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    if (!rx_en_i) begin
      state_d = S_IDLE;
      div_d   = '0;
      os_d    = '0;
    end else begin
      if (state_q != S_IDLE) begin
        div_d = tick ? '0 : div_q + 1'b1;
      end
      unique case (state_q)
        S_IDLE: begin
          // Counters held at zero so bit phase starts at the detected edge
          div_d = '0;
          os_d  = '0;
          if (!rxs_q) begin
            state_d = S_START;
          end
        end
        S_START: begin
          if (tick) begin
            if (os_q == 4'd7) begin
              os_d    = '0;
              idx_d   = '0;
              state_d = rxs_q ? S_IDLE : S_DATA;
            end else begin
              os_d = os_q + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            os_d = os_q + 1'b1;
            if (os_q == 4'd15) begin
              shift_d[idx_q] = rxs_q;
              idx_d          = idx_q + 1'b1;
              if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                state_d = S_STOP;
              end
            end
          end
        end
        S_STOP: begin
          if (tick) begin
            os_d = os_q + 1'b1;
            if (os_q == 4'd15) begin
              state_d = S_IDLE;
              if (rxs_q) begin
                // An ack in the same cycle frees the slot for the new byte
                if (!valid_q || rx_if.rx_ack) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
                end else begin
                  ovr_d = 1'b1;
                end
              end else begin
                ferr_d = 1'b1;
              end
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign rx_if.rx_data  = data_q;
  assign rx_if.rx_valid = valid_q;
  assign frame_err_o    = ferr_q;
  assign overrun_o      = ovr_q;
  assign busy_o         = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_b_rx.sv
// Directed bench for uart_b_rx: frames are scheduled into a timed event model
// derived from the frame latency rule, and outputs are compared every cycle.
module tb_uart_b_rx;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_en;
  logic [15:0] baud_div;
  logic        rx_in;
  logic        frame_err, overrun, busy;

  uart_b_rx_if #(.DATA_BITS(8)) rif();

  uart_b_rx #(.DATA_BITS(8), .DIV_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_en_i     (rx_en),
    .baud_div_i  (baud_div),
    .rx_in_i     (rx_in),
    .frame_err_o (frame_err),
    .overrun_o   (overrun),
    .busy_o      (busy),
    .rx_if       (rif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int ecount   = 0;
  int ferr_cnt = 0;

  always @(posedge clk) ecount <= ecount + 1;

  typedef struct {
    int         edge_n;
    bit         good;
    logic [7:0] data;
  } ev_t;

  ev_t        evq[$];
  logic       m_valid = 1'b0;
  logic       m_ovr   = 1'b0;
  logic       m_ferr  = 1'b0;
  logic [7:0] m_data  = 8'h00;
  bit         ack_s   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: frame outcomes land exactly 152*(div+1)+3 edges after the start bit is driven
  always @(negedge clk) begin
    bit old_v;
    if (rst_n !== 1'b1) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_ferr  = 1'b0;
      m_data  = 8'h00;
      evq.delete();
    end else begin
      old_v  = m_valid;
      m_ferr = 1'b0;
      if (ack_s) begin
        m_valid = 1'b0;
        m_ovr   = 1'b0;
      end
      if (evq.size() > 0 && evq[0].edge_n == ecount) begin
        if (evq[0].good) begin
          if (!old_v || ack_s) begin
            m_data  = evq[0].data;
            m_valid = 1'b1;
          end else begin
            m_ovr = 1'b1;
          end
        end else begin
          m_ferr = 1'b1;
        end
        $display("rx event @edge %0d data=%02h good=%0d", ecount, evq[0].data, evq[0].good);
        void'(evq.pop_front());
      end
    end
    check("cmp_rx_valid",  rif.rx_valid, m_valid);
    check("cmp_overrun",   overrun,      m_ovr);
    check("cmp_frame_err", frame_err,    m_ferr);
    if (m_valid) check("cmp_rx_data", rif.rx_data, m_data);
    if (frame_err === 1'b1) ferr_cnt++;
    ack_s = rif.rx_ack;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_b, input bit expect_ev);
    int  bc;
    ev_t e;
    bc = 16 * (int'(baud_div) + 1);
    if (expect_ev) begin
      e.edge_n = ecount + 152 * (int'(baud_div) + 1) + 3;
      e.good   = stop_b;
      e.data   = d;
      evq.push_back(e);
    end
    $display("tx frame %02h stop=%0d div=%0d", d, stop_b, baud_div);
    rx_in = 1'b0;
    step(bc);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      step(bc);
    end
    rx_in = stop_b;
    step(bc);
    rx_in = 1'b1;
  endtask

  task automatic do_ack();
    rif.rx_ack = 1'b1;
    step(1);
    rif.rx_ack = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int         s, lat, drop_at, f0;
    bit         seen_busy;
    logic [7:0] got [3];
    logic       gv  [3];
    logic [7:0] lb  [3];

    rst_n      = 1'b0;
    rx_en      = 1'b1;
    baud_div   = 16'd3;
    rx_in      = 1'b1;
    rif.rx_ack = 1'b0;
    step(3);
    check("rst_rx_valid",  rif.rx_valid, 0);
    check("rst_rx_data",   rif.rx_data,  0);
    check("rst_busy",      busy,         0);
    check("rst_overrun",   overrun,      0);
    check("rst_frame_err", frame_err,    0);
    rst_n = 1'b1;
    step(5);

    // 1: basic frame 0xA5, latency 611 clk at div=3
    f0  = ferr_cnt;
    s   = ecount;
    lat = -1;
    fork
      send_frame(8'hA5, 1'b1, 1'b1);
      begin
        for (int k = 0; k < 700 && lat < 0; k++) begin
          @(negedge clk);
          if (rif.rx_valid === 1'b1) lat = ecount - s;
        end
      end
    join
    step(1);
    check("t1_latency",   lat,              611);
    check("t1_rx_data",   rif.rx_data,      8'hA5);
    check("t1_frame_err", ferr_cnt - f0,    0);
    do_ack();
    check("t1_ack_valid", rif.rx_valid,     0);
    step(10);

    // 2: 20-clk glitch is rejected
    s         = ecount;
    seen_busy = 1'b0;
    drop_at   = -1;
    rx_in     = 1'b0;
    fork
      begin
        step(20);
        rx_in = 1'b1;
      end
      begin
        for (int k = 0; k < 60 && drop_at < 0; k++) begin
          @(negedge clk);
          if (busy === 1'b1) seen_busy = 1'b1;
          else if (seen_busy) drop_at = ecount - s;
        end
      end
    join
    step(1);
    check("t2_busy_seen",  seen_busy,                      1);
    check("t2_busy_drop",  (drop_at > 0 && drop_at <= 35), 1);
    check("t2_rx_valid",   rif.rx_valid,                   0);
    step(20);

    // 3: framing error at div=0, then good 0x81
    baud_div = 16'd0;
    step(5);
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 1'b1);
    step(40);
    check("t3_ferr_pulses", ferr_cnt - f0, 1);
    check("t3_rx_valid",    rif.rx_valid,  0);
    send_frame(8'h81, 1'b1, 1'b1);
    step(5);
    check("t3_rx_data",  rif.rx_data,  8'h81);
    check("t3_rx_valid2", rif.rx_valid, 1);
    do_ack();
    step(10);

    // 4: overrun on back-to-back frames without ack
    baud_div = 16'd3;
    step(5);
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1);
    step(5);
    check("t4_rx_data",  rif.rx_data,  8'h11);
    check("t4_overrun",  overrun,      1);
    check("t4_rx_valid", rif.rx_valid, 1);
    do_ack();
    check("t4_ack_overrun", overrun,      0);
    check("t4_ack_valid",   rif.rx_valid, 0);
    send_frame(8'h33, 1'b1, 1'b1);
    step(5);
    check("t4_rx_data3", rif.rx_data, 8'h33);

    // 5: reset in the middle of a 0xFF frame (0x33 still pending)
    rx_in = 1'b0;
    step(64);
    rx_in = 1'b1;
    step(100);
    check("t5_busy_before", busy, 1);
    rst_n = 1'b0;
    step(3);
    check("t5_rst_valid", rif.rx_valid, 0);
    check("t5_rst_data",  rif.rx_data,  0);
    check("t5_rst_ovr",   overrun,      0);
    check("t5_rst_busy",  busy,         0);
    rst_n = 1'b1;
    step(700);
    check("t5_no_spurious", rif.rx_valid, 0);
    send_frame(8'h5A, 1'b1, 1'b1);
    step(5);
    check("t5_rx_data", rif.rx_data, 8'h5A);
    do_ack();
    step(10);

    // 7: receiver disabled ignores a whole frame
    rx_en     = 1'b0;
    seen_busy = 1'b0;
    fork
      send_frame(8'h77, 1'b1, 1'b0);
      begin
        for (int k = 0; k < 640; k++) begin
          @(negedge clk);
          if (busy === 1'b1) seen_busy = 1'b1;
        end
      end
    join
    step(1);
    check("t7_busy_disabled",  seen_busy,    0);
    check("t7_valid_disabled", rif.rx_valid, 0);
    rx_en = 1'b1;
    step(10);

    // 6: loopback-style sequence 0x00, 0xFF, 0x55
    lb[0] = 8'h00;
    lb[1] = 8'hFF;
    lb[2] = 8'h55;
    for (int i = 0; i < 3; i++) begin
      send_frame(lb[i], 1'b1, 1'b1);
      step(5);
      got[i] = rif.rx_data;
      gv[i]  = rif.rx_valid;
      do_ack();
      step(5);
    end
    check("t6_byte0", got[0], 8'h00);
    check("t6_byte1", got[1], 8'hFF);
    check("t6_byte2", got[2], 8'h55);
    check("t6_valid0", gv[0], 1);
    check("t6_valid1", gv[1], 1);
    check("t6_valid2", gv[2], 1);
    step(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/uart_b_rx.md
Name: uart_b_rx

Overview:
- Serial receive stage that consumes the UART binary peripheral's `tx_out` line (or an external 8N1 line).
- Recovers bytes using 16x oversampling and presents each byte to a consumer through a valid/ack handshake.
- Flags framing errors and overrun.
- Sits directly downstream of the UART transmit path and serves as the loopback/receive partner in system tests.

Parameters:
- DATA_BITS, 8, number of data bits per frame (LSB first); no parity; one stop bit.
- DIV_W, 16, width of the baud divisor input.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset (0 = reset).
- rx_en  input  1  receiver enable; 0 forces IDLE and holds the tick counters cleared.
- baud_div  input  DIV_W  oversample tick period minus one; one tick every baud_div+1 clk cycles.
- rx_in  input  1  serial line; idle high; asynchronous to clk.
- rx_ack  input  1  consumer acknowledge; clears rx_valid and overrun.
- rx_data  output  DATA_BITS  last received byte; held until the next good frame.
- rx_valid  output  1  level; byte available.
- frame_err  output  1  one-cycle pulse; stop bit sampled low.
- overrun  output  1  sticky; a good frame completed while rx_valid=1.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - FSM=IDLE; synchronizer flops=1; all counters=0.
- Input synchronization:
  - 2-flop synchronizer on rx_in, reset to 1. All decisions use the synchronized value rxs.
- Tick generator:
  - Divider counts 0..baud_div; `tick` is asserted when the count equals baud_div, then the count wraps to 0.
  - baud_div=0 gives a tick every cycle.
  - Divider and the 4-bit oversample counter are both cleared on the IDLE->START transition, so bit phase aligns to the detected edge.
  - A change to baud_div mid-frame takes effect on the next divider wrap; no protection is provided.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE:
    - if rx_en=1 and rxs=0 -> START.
    - busy=0.
  - START: on the 8th tick (mid start bit), sample rxs.
    - rxs=0 -> DATA; oversample counter cleared; bit index cleared.
    - rxs=1 -> IDLE (glitch rejected; no outputs change).
  - DATA:
    - every 16th tick, shift rxs into bit [index] of the shift register (LSB first) and increment index.
    - after DATA_BITS samples -> STOP.
  - STOP: on the 16th tick, sample rxs.
    - rxs=1 (good frame):
      - if rx_valid=0: rx_data<=shift register; rx_valid<=1 the next clk.
      - if rx_valid=1: overrun<=1; rx_data and rx_valid unchanged; the new byte is discarded.
    - rxs=0 (framing error):
      - frame_err=1 for exactly one clk.
      - rx_data and rx_valid unchanged.
    - Either way -> IDLE in the same cycle. A start edge already low is detected on the next clk.
- rx_en=0 in any state:
  - next clk -> IDLE; partial frame discarded.
  - rx_valid, rx_data and overrun are retained.
- Handshake:
  - rx_ack=1 with rx_valid=1 clears rx_valid and overrun on the next clk.
  - rx_ack with rx_valid=0 clears overrun only.
  - Simultaneous good-STOP completion and rx_ack in the same cycle: the ack wins for the old byte; the new byte is loaded and rx_valid stays 1; no overrun.
- Latency:
  - from the synchronized falling edge to the rx_valid rise = (8 + 16*DATA_BITS + 16) ticks + 1 clk.
  - DATA_BITS=8: 152*(baud_div+1) + 1 clk, plus 2 clk synchronizer delay from the rx_in pin.
- Reset mid-frame: immediate return to the reset values; no spurious rx_valid or frame_err after release.
- busy=1 in START, DATA and STOP.

Test Plan:
1. baud_div=3 (64 clk/bit); drive 8N1 frame 0xA5 -> rx_data=0xA5, rx_valid rises 611 clk after the rx_in fall; frame_err never 1; after rx_ack, rx_valid=0.
2. baud_div=3; rx_in low for 20 clk, then high (shorter than the 32-clk half bit) -> FSM returns to IDLE; rx_valid=0; busy drops within 35 clk.
3. baud_div=0; frame 0x3C with stop bit 0 -> frame_err is a single 1-clk pulse; rx_valid stays 0; a following good frame 0x81 is received correctly.
4. baud_div=3; send 0x11 then 0x22 back-to-back without rx_ack -> rx_data=0x11, overrun=1; rx_ack clears both; third frame 0x33 is received.
5. Assert rst=0 in the middle of the DATA state of frame 0xFF, release, then send 0x5A -> all outputs 0 during reset; only 0x5A is delivered.
6. Loopback with the UART binary peripheral: connect `tx_out` to rx_in, write 0x00, 0xFF and 0x55 through its bus at a matching baud -> three rx_valid events carrying identical bytes in order.
